// File: rtl/riscv_axi_rd_arb.sv
// riscv_axi_rd_arb: shares one AXI4 read master (AR + R channels) between
// the instruction fetch unit (requester 0) and the load/store unit
// (requester 1). Round-robin grant, one outstanding read at a time, and
// R beats are routed combinationally back to the owner until RLAST.
module riscv_axi_rd_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            rq_arvalid,
    input  logic [2*ADDR_W-1:0]   rq_araddr,
    input  logic [15:0]           rq_arlen,
    output logic [1:0]            rq_arready,
    output logic [1:0]            rq_rvalid,
    output logic [DATA_W-1:0]     rq_rdata,
    output logic [1:0]            rq_rresp,
    output logic                  rq_rlast,
    input  logic [1:0]            rq_rready,
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    output logic [ID_W-1:0]       m_arid,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [ID_W-1:0]       m_rid,
    output logic                  m_rready,
    output logic                  id_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                lastGrant_q, lastGrant_d;
    logic                idErr_q, idErr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic                grantSel;
    logic [ID_W-1:0]     ownerId;

    // The AR ID is simply the owner index widened to the AXI ID width.
    assign ownerId  = ID_W'(owner_q);
    assign m_arid   = ownerId;
    assign m_araddr = addr_q;
    assign m_arlen  = len_q;
    assign id_err   = idErr_q;

    // Next-state and output decode: arbitration in IDLE, AR presentation in
    // ADDR, zero-latency R routing to the owner in DATA.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        idErr_d     = idErr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        grantSel    = 1'b0;
        rq_arready  = 2'b00;
        rq_rvalid   = 2'b00;
        rq_rdata    = '0;
        rq_rresp    = 2'b00;
        rq_rlast    = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset && (rq_arvalid != 2'b00)) begin
                    if (rq_arvalid == 2'b11) begin
                        grantSel = ~lastGrant_q;
                    end else begin
                        grantSel = rq_arvalid[1];
                    end
                    rq_arready  = grantSel ? 2'b10 : 2'b01;
                    owner_d     = grantSel;
                    lastGrant_d = grantSel;
                    addr_d      = grantSel ? rq_araddr[ADDR_W +: ADDR_W]
                                           : rq_araddr[0 +: ADDR_W];
                    len_d       = grantSel ? rq_arlen[15:8] : rq_arlen[7:0];
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rready  = rq_rready[owner_q];
                rq_rvalid = owner_q ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
                rq_rdata  = m_rdata;
                rq_rresp  = m_rresp;
                rq_rlast  = m_rlast;
                if (m_rvalid && m_rready) begin
                    if (m_rid != ownerId) begin
                        idErr_d = 1'b1;
                    end
                    if (m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight and makes
    // requester 0 the winner of the next contest.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            idErr_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            idErr_q     <= idErr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
        end
    end

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Testbench for riscv_axi_rd_arb: directed transactions push expected AR
// and R beats into queues; a negedge monitor pops and compares them
// whenever the DUT completes a handshake.
module tb_riscv_axi_rd_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [IW-1:0] id;
   } arExp_t;

   typedef struct packed {
      logic          idx;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beatExp_t;

   logic            clock = 1'b0;
   logic            reset;
   logic [1:0]      rq_arvalid;
   logic [2*AW-1:0] rq_araddr;
   logic [15:0]     rq_arlen;
   logic [1:0]      rq_arready;
   logic [1:0]      rq_rvalid;
   logic [DW-1:0]   rq_rdata;
   logic [1:0]      rq_rresp;
   logic            rq_rlast;
   logic [1:0]      rq_rready;
   logic            m_arvalid;
   logic [AW-1:0]   m_araddr;
   logic [7:0]      m_arlen;
   logic [IW-1:0]   m_arid;
   logic            m_arready;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic [IW-1:0]   m_rid;
   logic            m_rready;
   logic            id_err;

   arExp_t   arQ[$];
   beatExp_t rQ[$];
   arExp_t   arE;
   beatExp_t bE;
   int       compared = 0;
   int       mismatched = 0;

   riscv_axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .clock(clock), .reset(reset),
      .rq_arvalid(rq_arvalid), .rq_araddr(rq_araddr), .rq_arlen(rq_arlen),
      .rq_arready(rq_arready), .rq_rvalid(rq_rvalid), .rq_rdata(rq_rdata),
      .rq_rresp(rq_rresp), .rq_rlast(rq_rlast), .rq_rready(rq_rready),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arid(m_arid), .m_arready(m_arready), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rid(m_rid), .m_rready(m_rready), .id_err(id_err)
   );

   // Free-running core clock.
   always #5 clock = ~clock;

   // Single comparison point shared by the monitor and the directed checks.
   function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every completed AR or R handshake is matched against the
   // oldest expected entry.
   always @(negedge clock) begin
      if (m_arvalid && m_arready) begin
         if (arQ.size() == 0) begin
            checkOutput("ar_unexpected", 1, 0);
         end else begin
            arE = arQ.pop_front();
            checkOutput("ar_addr", m_araddr, arE.addr);
            checkOutput("ar_len", m_arlen, arE.len);
            checkOutput("ar_id", m_arid, arE.id);
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rq_rvalid[i] && rq_rready[i]) begin
            if (rQ.size() == 0) begin
               checkOutput("beat_unexpected", 1, 0);
            end else begin
               bE = rQ.pop_front();
               checkOutput("beat_owner", i, bE.idx);
               checkOutput("beat_data", rq_rdata, bE.data);
               checkOutput("beat_resp", rq_rresp, bE.resp);
               checkOutput("beat_last", rq_rlast, bE.last);
            end
         end
      end
   end

   // Hard stop in case something leaves the bench waiting forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_arready"}, rq_arready, 0);
      checkOutput({tag, "_rvalid"}, rq_rvalid, 0);
      checkOutput({tag, "_rdata"}, rq_rdata, 0);
      checkOutput({tag, "_rresp"}, rq_rresp, 0);
      checkOutput({tag, "_rlast"}, rq_rlast, 0);
      checkOutput({tag, "_marvalid"}, m_arvalid, 0);
      checkOutput({tag, "_maraddr"}, m_araddr, 0);
      checkOutput({tag, "_marlen"}, m_arlen, 0);
      checkOutput({tag, "_marid"}, m_arid, 0);
      checkOutput({tag, "_mrready"}, m_rready, 0);
      checkOutput({tag, "_iderr"}, id_err, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // Raise the request mask and expect requester expG to be granted.
   task automatic applyStimulus(input logic [1:0] mask, input logic expG,
                                input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1);
      int k = 0;
      arExp_t e;
      e.addr = expG ? a1 : a0;
      e.len  = expG ? l1 : l0;
      e.id   = IW'(expG);
      arQ.push_back(e);
      rq_arvalid = mask;
      rq_araddr  = {a1, a0};
      rq_arlen   = {l1, l0};
      @(negedge clock);
      while (rq_arready == 2'b00 && k < 20) begin
         @(negedge clock);
         k++;
      end
      checkOutput("arready_grant", rq_arready, expG ? 2'b10 : 2'b01);
      @(posedge clock); #1;
      rq_arvalid[expG] = 1'b0;
   endtask

   // Slave AR side: hold off m_arready for `stall` cycles, then accept.
   task automatic serveAr(input int stall, input logic [31:0] expAddr, input logic [3:0] expId);
      int k = 0;
      m_arready = 1'b0;
      for (int c = 0; c < stall; c++) begin
         @(negedge clock);
         checkOutput("ar_hold_valid", m_arvalid, 1);
         checkOutput("ar_hold_addr", m_araddr, expAddr);
         checkOutput("ar_hold_id", m_arid, expId);
         if (c == 0) checkOutput("arready_pulse", rq_arready, 0);
         @(posedge clock); #1;
      end
      m_arready = 1'b1;
      @(negedge clock);
      while (!m_arvalid && k < 20) begin
         @(negedge clock);
         k++;
      end
      checkOutput("ar_seen", m_arvalid, 1);
      @(posedge clock); #1;
      m_arready = 1'b0;
      @(negedge clock);
      checkOutput("ar_drop", m_arvalid, 0);
      @(posedge clock); #1;
   endtask

   // Slave R side: deliver n beats of a `total`-beat burst to owner.
   task automatic serveR(input logic owner, input int n, input int total,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [3:0] rid, input logic toggle);
      logic [31:0] d[4];
      logic phase = 1'b1;
      logic done;
      int k;
      beatExp_t b;
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < n; i++) begin
         b.idx  = owner;
         b.data = d[i];
         b.resp = 2'(i);
         b.last = (i == total - 1);
         rQ.push_back(b);
         m_rvalid = 1'b1;
         m_rdata  = d[i];
         m_rresp  = 2'(i);
         m_rlast  = (i == total - 1);
         m_rid    = rid;
         done = 1'b0;
         k = 0;
         while (!done && k < 20) begin
            rq_rready[owner]  = toggle ? phase : 1'b1;
            rq_rready[!owner] = ~rq_rready[owner];
            @(negedge clock);
            checkOutput("rready_mirror", m_rready, rq_rready[owner]);
            checkOutput("rvalid_other", rq_rvalid[!owner], 0);
            checkOutput("arready_busy", rq_arready, 0);
            done = m_rready;
            @(posedge clock); #1;
            phase = ~phase;
            k++;
         end
         if (!done) checkOutput("beat_timeout", 0, 1);
      end
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      rq_rready = 2'b00;
   endtask

   initial begin
      reset = 1'b1; rq_arvalid = 0; rq_araddr = 0; rq_arlen = 0; rq_rready = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
      @(posedge clock); @(negedge clock);
      checkAllZero("reset");
      @(posedge clock); #1;
      reset = 1'b0;

      // Single request from fetch.
      applyStimulus(2'b01, 0, 32'h1000, 8'd0, 32'h0, 8'd0);
      serveAr(0, 32'h1000, 4'd0);
      serveR(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 4'd0, 0);
      @(negedge clock);
      checkOutput("id_err_clean", id_err, 0);
      @(posedge clock); #1;

      // Simultaneous requests after reset: alternation 0,1,0,1.
      doReset();
      applyStimulus(2'b11, 0, 32'h2000, 8'd0, 32'h2100, 8'd0);
      serveAr(0, 32'h2000, 4'd0);
      serveR(0, 1, 1, 32'hA0A0A0A0, 0, 0, 0, 4'd0, 0);
      applyStimulus(2'b10, 1, 32'h2000, 8'd0, 32'h2100, 8'd0);
      serveAr(0, 32'h2100, 4'd1);
      serveR(1, 1, 1, 32'hB1B1B1B1, 0, 0, 0, 4'd1, 0);
      applyStimulus(2'b11, 0, 32'h2000, 8'd0, 32'h2100, 8'd0);
      serveAr(0, 32'h2000, 4'd0);
      serveR(0, 1, 1, 32'hA2A2A2A2, 0, 0, 0, 4'd0, 0);
      applyStimulus(2'b10, 1, 32'h2000, 8'd0, 32'h2100, 8'd0);
      serveAr(0, 32'h2100, 4'd1);
      serveR(1, 1, 1, 32'hB3B3B3B3, 0, 0, 0, 4'd1, 0);

      // Four-beat burst to LSU with toggling rready; fetch waits meanwhile.
      applyStimulus(2'b10, 1, 32'h5000, 8'd0, 32'h4000, 8'd3);
      serveAr(0, 32'h4000, 4'd1);
      rq_arvalid[0] = 1'b1;
      serveR(1, 4, 4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'd1, 1);

      // Pending fetch gets granted once the burst ends; AR stalls 5 cycles
      // and the slave answers with a wrong ID.
      applyStimulus(2'b01, 0, 32'h5000, 8'd0, 32'h4000, 8'd3);
      serveAr(5, 32'h5000, 4'd0);
      serveR(0, 1, 1, 32'h55AA55AA, 0, 0, 0, 4'd3, 0);
      @(negedge clock);
      checkOutput("id_err_set", id_err, 1);
      @(posedge clock); #1;
      applyStimulus(2'b10, 1, 32'h5000, 8'd0, 32'h6000, 8'd0);
      serveAr(0, 32'h6000, 4'd1);
      serveR(1, 1, 1, 32'h66666666, 0, 0, 0, 4'd1, 0);
      @(negedge clock);
      checkOutput("id_err_sticky", id_err, 1);
      @(posedge clock); #1;

      // Reset during beat 2 of a 4-beat fetch burst.
      applyStimulus(2'b01, 0, 32'h7000, 8'd3, 32'h6000, 8'd0);
      serveAr(0, 32'h7000, 4'd0);
      serveR(0, 2, 4, 32'h70000000, 32'h70000001, 0, 0, 4'd0, 0);
      m_rvalid = 1'b1; m_rdata = 32'h70000002; m_rid = 4'd0; rq_rready = 2'b00;
      @(negedge clock);
      checkOutput("midburst_busy", m_arvalid, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); @(negedge clock);
      checkAllZero("midrst");
      @(posedge clock); #1;
      reset = 1'b0;
      m_rvalid = 1'b0; m_rdata = 0;
      applyStimulus(2'b11, 0, 32'h8000, 8'd0, 32'h8100, 8'd0);
      serveAr(0, 32'h8000, 4'd0);
      serveR(0, 1, 1, 32'h80808080, 0, 0, 0, 4'd0, 0);
      applyStimulus(2'b10, 1, 32'h8000, 8'd0, 32'h8100, 8'd0);
      serveAr(0, 32'h8100, 4'd1);
      serveR(1, 1, 1, 32'h81818181, 0, 0, 0, 4'd1, 0);

      @(negedge clock);
      checkOutput("arq_drained", arQ.size(), 0);
      checkOutput("rq_drained", rQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/riscv_axi_rd_arb.md
Name: riscv_axi_rd_arb

Overview:
Arbiter that shares the core's single AXI4 read-address/read-data master port between two read requesters. Requester 0 is the instruction fetch unit; requester 1 is the load/store unit. It grants one requester at a time round-robin and issues that requester's AR transfer with an ID tag. It then routes every R beat of the burst back to the owner until RLAST. One outstanding read transaction at a time.

Parameters:
ADDR_W, 32, read address width
DATA_W, 32, read data width
ID_W, 4, AXI ID width; must be >= 1

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
rq_arvalid  in  2  per-requester read request valid; bit N = requester N
rq_araddr  in  2*ADDR_W  per-requester address; bits [N*ADDR_W +: ADDR_W]
rq_arlen  in  2*8  per-requester AXI burst length (beats-1)
rq_arready  out  2  per-requester request accepted
rq_rvalid  out  2  per-requester read beat valid
rq_rdata  out  DATA_W  read beat data, shared by both requesters (qualify with rq_rvalid)
rq_rresp  out  2  read beat response, shared
rq_rlast  out  1  last beat of burst, shared
rq_rready  in  2  per-requester beat accept
m_arvalid  out  1  master AR valid
m_araddr  out  ADDR_W  master AR address
m_arlen  out  8  master AR burst length
m_arid  out  ID_W  master AR ID = owner index, zero-extended
m_arready  in  1  slave AR ready
m_rvalid  in  1  slave R valid
m_rdata  in  DATA_W  slave R data
m_rresp  in  2  slave R response
m_rlast  in  1  slave R last
m_rid  in  ID_W  slave R ID
m_rready  out  1  master R ready
id_err  out  1  sticky flag: an R beat arrived with m_rid != owner ID

Behaviour:
- Reset (synchronous, checked every clock edge; overrides all else):
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins first contest), id_err=0.
  - All outputs 0.
  - Reset mid-burst abandons the transaction with no cleanup; any remaining slave beats are the system's responsibility.
- State machine IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - No request pending: stay in IDLE.
  - Only one rq_arvalid bit set: grant that requester.
  - Both bits set: grant ~last_grant.
  - On grant, in the same cycle: pulse rq_arready[g]=1 for exactly one cycle (the request is consumed); latch araddr/arlen[g]; owner<=g; last_grant<=g; next state ADDR.
  - rq_arready is only ever asserted in IDLE; it is 0 in every other state.
- ADDR:
  - m_arvalid=1 with the latched addr/len and m_arid=owner, all held stable until m_arready.
  - On m_arvalid & m_arready, next state DATA; m_arvalid drops the next cycle.
  - First AR can be presented 1 cycle after the requester's handshake.
- DATA (combinational pass-through, 0-cycle latency):
  - rq_rvalid[owner]=m_rvalid; the other rq_rvalid bit is 0.
  - rq_rdata/rresp/rlast = m_rdata/m_rresp/m_rlast.
  - m_rready=rq_rready[owner].
  - On any beat handshake (m_rvalid & m_rready) with m_rid != owner ID, set id_err; the beat is still forwarded.
  - On a handshake beat with m_rlast=1, next state IDLE.
  - Back-to-back transactions incur 1 IDLE cycle; minimum period per single-beat read is 3 cycles plus slave latency.
- Outside DATA: m_rready=0, rq_rvalid=0. Stray slave beats arriving outside DATA stall indefinitely and are never acknowledged.
- arlen is passed through unmodified; no beat counting is done, and burst end is defined solely by m_rlast.
- A requester deasserting rq_arvalid before being granted is legal; requests are sampled only in IDLE.

Test Plan:
- Single request: rq_arvalid=01, addr 0x1000, len 0, slave ARREADY on first cycle, 1 beat 0xDEADBEEF with RLAST → rq_arready[0] pulses once; m_arid=0; rq_rvalid[0] with 0xDEADBEEF; return to IDLE.
- Simultaneous requests after reset: rq_arvalid=11 → requester 0 granted first, then requester 1 (m_arid=1). Repeat → strict alternation 0,1,0,1.
- Burst with backpressure: requester 1, len 3, rq_rready toggling 1010… → m_rready mirrors rq_rready[1]; exactly 4 beats delivered in order; IDLE only after the RLAST handshake; rq_rvalid[0] stays 0 throughout.
- AR stall: m_arready held low 5 cycles → m_arvalid/m_araddr/m_arid stable for all 5 cycles; transition to DATA on the cycle after the handshake.
- ID mismatch: owner 0, slave returns rid=3 → id_err rises after that beat and stays 1 across later transactions until reset.
- Reset mid-burst: assert reset during beat 2 of 4 → all outputs 0 next cycle, state IDLE, id_err=0; next simultaneous request grants requester 0.
